// File: rtl/intersection_phase_scheduler_if.sv
// Sensor inputs and lamp/phase outputs of the intersection phase scheduler.
// The scheduler binds to the slave modport; whoever drives the sensors uses master.
interface intersection_phase_scheduler_if;
  logic       i_car_b;
  logic       i_emergency;
  logic       o_a_red;
  logic       o_a_yellow;
  logic       o_a_green;
  logic       o_b_red;
  logic       o_b_yellow;
  logic       o_b_green;
  logic [2:0] o_phase;
  logic       o_emergency_active;

  modport master (
    output i_car_b, i_emergency,
    input  o_a_red, o_a_yellow, o_a_green,
    input  o_b_red, o_b_yellow, o_b_green,
    input  o_phase, o_emergency_active
  );

  modport slave (
    input  i_car_b, i_emergency,
    output o_a_red, o_a_yellow, o_a_green,
    output o_b_red, o_b_yellow, o_b_green,
    output o_phase, o_emergency_active
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer: A rests green, a latched side-road request hands over to B.
// Optional emergency preemption (all-red hold) is enabled by defining TLC_EMERGENCY_PREEMPT_EN.
module intersection_phase_scheduler #(
  parameter int MIN_GREEN_A = 8,
  parameter int GREEN_B     = 5,
  parameter int YELLOW      = 3,
  parameter int ALL_RED     = 2
) (
  input logic                          i_clk,
  input logic                          i_reset,
  intersection_phase_scheduler_if.slave bus
);

  localparam int MAX_AB  = (MIN_GREEN_A > GREEN_B) ? MIN_GREEN_A : GREEN_B;
  localparam int MAX_YR  = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
  localparam int MAX_LEN = (MAX_AB > MAX_YR) ? MAX_AB : MAX_YR;
  localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [TW-1:0] T_MIN_GREEN_A = TW'(MIN_GREEN_A - 1);
  localparam logic [TW-1:0] T_GREEN_B     = TW'(GREEN_B - 1);
  localparam logic [TW-1:0] T_YELLOW      = TW'(YELLOW - 1);
  localparam logic [TW-1:0] T_ALL_RED     = TW'(ALL_RED - 1);

  typedef enum logic [2:0] {
    A_GREEN    = 3'd0,
    A_YELLOW   = 3'd1,
    ALL_RED_AB = 3'd2,
    B_GREEN    = 3'd3,
    B_YELLOW   = 3'd4,
    ALL_RED_BA = 3'd5
  } phase_e;

  typedef struct packed {
    logic a_red;
    logic a_yellow;
    logic a_green;
    logic b_red;
    logic b_yellow;
    logic b_green;
  } lamps_t;

  function automatic lamps_t decode(phase_e p);
    case (p)
      A_GREEN:  decode = '{a_green: 1'b1, b_red: 1'b1, default: 1'b0};
      A_YELLOW: decode = '{a_yellow: 1'b1, b_red: 1'b1, default: 1'b0};
      B_GREEN:  decode = '{a_red: 1'b1, b_green: 1'b1, default: 1'b0};
      B_YELLOW: decode = '{a_red: 1'b1, b_yellow: 1'b1, default: 1'b0};
      default:  decode = '{a_red: 1'b1, b_red: 1'b1, default: 1'b0};
    endcase
  endfunction

  phase_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          req_b_q, req_b_d;
  lamps_t        lamps_q, lamps_d;
  logic          emerg_req;   // forces a green into its yellow
  logic          emerg_hold;  // blocks all-red exit and keeps reloading the timer
  logic          emerg_seen;  // preempted all-red always returns to A

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == '0) ? '0 : timer_q - 1'b1;
    req_b_d = req_b_q | (bus.i_car_b && (state_q != B_GREEN));
    case (state_q)
      A_GREEN: begin
        if (emerg_req || ((timer_q == '0) && (req_b_q || bus.i_car_b))) begin
          state_d = A_YELLOW;
          timer_d = T_YELLOW;
        end
      end
      A_YELLOW: begin
        if (timer_q == '0) begin
          state_d = ALL_RED_AB;
          timer_d = T_ALL_RED;
        end
      end
      ALL_RED_AB, ALL_RED_BA: begin
        if (emerg_hold) begin
          timer_d = T_ALL_RED;
        end else if (timer_q == '0) begin
          if ((state_q == ALL_RED_BA) || emerg_seen) begin
            state_d = A_GREEN;
            timer_d = T_MIN_GREEN_A;
          end else begin
            state_d = B_GREEN;
            timer_d = T_GREEN_B;
            req_b_d = 1'b0;  // entry clear beats a same-cycle set
          end
        end
      end
      B_GREEN: begin
        if (emerg_req || (timer_q == '0)) begin
          state_d = B_YELLOW;
          timer_d = T_YELLOW;
        end
      end
      B_YELLOW: begin
        if (timer_q == '0) begin
          state_d = ALL_RED_BA;
          timer_d = T_ALL_RED;
        end
      end
      default: begin
        state_d = ALL_RED_BA;
        timer_d = T_ALL_RED;
      end
    endcase
    lamps_d = decode(state_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ALL_RED_BA;
      timer_q <= T_ALL_RED;
      req_b_q <= 1'b0;
      lamps_q <= decode(ALL_RED_BA);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_b_q <= req_b_d;
      lamps_q <= lamps_d;
    end
  end

`ifdef TLC_EMERGENCY_PREEMPT_EN
  logic emerg_active_q, emerg_active_d;
  logic emerg_seen_q, emerg_seen_d;
  logic in_all_red_d;

  assign emerg_req  = bus.i_emergency;
  // The release edge also reloads, so a full ALL_RED clearance follows release.
  assign emerg_hold = bus.i_emergency | emerg_active_q;
  assign emerg_seen = emerg_seen_q;

  always_comb begin
    in_all_red_d   = (state_d == ALL_RED_AB) || (state_d == ALL_RED_BA);
    emerg_active_d = bus.i_emergency && in_all_red_d;
    emerg_seen_d   = in_all_red_d && (emerg_seen_q || emerg_active_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      emerg_active_q <= 1'b0;
      emerg_seen_q   <= 1'b0;
    end else begin
      emerg_active_q <= emerg_active_d;
      emerg_seen_q   <= emerg_seen_d;
    end
  end

  assign bus.o_emergency_active = emerg_active_q;
`else
  logic unused_emergency;
  assign unused_emergency       = bus.i_emergency;
  assign emerg_req              = 1'b0;
  assign emerg_hold             = 1'b0;
  assign emerg_seen             = 1'b0;
  assign bus.o_emergency_active = 1'b0;
`endif

  assign bus.o_phase    = state_q;
  assign bus.o_a_red    = lamps_q.a_red;
  assign bus.o_a_yellow = lamps_q.a_yellow;
  assign bus.o_a_green  = lamps_q.a_green;
  assign bus.o_b_red    = lamps_q.b_red;
  assign bus.o_b_yellow = lamps_q.b_yellow;
  assign bus.o_b_green  = lamps_q.b_green;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Table-driven check of intersection_phase_scheduler with a scoreboard queue of expected outputs.
// Each table row is a run of identical-input cycles with the phase expected after every edge.
module tb_intersection_phase_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler #(
    .MIN_GREEN_A(8),
    .GREEN_B    (5),
    .YELLOW     (3),
    .ALL_RED    (2)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  typedef struct {
    logic       rst;
    logic       car;
    logic       em;
    int         n;
    logic [2:0] ph;
    logic       act;
  } vec_t;

  typedef struct {
    logic [2:0] ph;
    logic [5:0] lamps;
    logic       act;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;

  // {a_red, a_yellow, a_green, b_red, b_yellow, b_green} for each phase code
  function automatic logic [5:0] lamps_for(logic [2:0] ph);
    case (ph)
      3'd0:    lamps_for = 6'b001_100;
      3'd1:    lamps_for = 6'b010_100;
      3'd3:    lamps_for = 6'b100_001;
      3'd4:    lamps_for = 6'b100_010;
      default: lamps_for = 6'b100_100;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic car, input logic em, input int n,
                     input logic [2:0] ph, input logic act);
    vec_t v;
    v.rst = rst; v.car = car; v.em = em; v.n = n; v.ph = ph; v.act = act;
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input int idx, input int k);
    exp_t e;
    exp_t got;
    reset           = v.rst;
    bus.i_car_b     = v.car;
    bus.i_emergency = v.em;
    e.ph    = v.ph;
    e.lamps = lamps_for(v.ph);
    e.act   = v.act;
    sb.push_back(e);
    @(posedge clk);
    #1;
    started = 1'b1;
    got = sb.pop_front();
    check($sformatf("row%0d.cyc%0d phase", idx, k), {5'b0, bus.o_phase}, {5'b0, got.ph});
    check($sformatf("row%0d.cyc%0d lamps", idx, k),
          {2'b0, bus.o_a_red, bus.o_a_yellow, bus.o_a_green,
                 bus.o_b_red, bus.o_b_yellow, bus.o_b_green},
          {2'b0, got.lamps});
    check($sformatf("row%0d.cyc%0d emerg_active", idx, k),
          {7'b0, bus.o_emergency_active}, {7'b0, got.act});
  endtask

  // Safety invariant on every cycle: one lamp per road, never two greens.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ((bus.o_a_green && bus.o_b_green) ||
          ($countones({bus.o_a_red, bus.o_a_yellow, bus.o_a_green}) != 1) ||
          ($countones({bus.o_b_red, bus.o_b_yellow, bus.o_b_green}) != 1)) begin
        errors++;
        $display("FAIL lamp_safety at %0t: A=%b%b%b B=%b%b%b required one lamp each, not both green",
                 $time, bus.o_a_red, bus.o_a_yellow, bus.o_a_green,
                 bus.o_b_red, bus.o_b_yellow, bus.o_b_green);
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.i_car_b     = 1'b0;
    bus.i_emergency = 1'b0;

    // Reset for 2 cycles, 2 all-red cycles, then A green resting with no car.
    add(1, 0, 0, 2, 5, 0);
    add(0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 200, 0, 0);

    // Car pulse in A green cycle 3: A lasts 8, then one full B service.
    // Car seen only on the edge into B green and during B green: no re-service.
    add(1, 0, 0, 2, 5, 0);
    add(0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 3, 0, 0);
    add(0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 2, 2, 0);
    add(0, 1, 0, 5, 3, 0);
    add(0, 0, 0, 3, 4, 0);
    add(0, 0, 0, 2, 5, 0);
    add(0, 0, 0, 30, 0, 0);

    // Car held high: 23-cycle cycle of 8+3+2+5+3+2, two full periods.
    add(1, 1, 0, 2, 5, 0);
    add(0, 1, 0, 1, 5, 0);
    add(0, 1, 0, 8, 0, 0);
    for (int p = 0; p < 2; p++) begin
      add(0, 1, 0, 3, 1, 0);
      add(0, 1, 0, 2, 2, 0);
      add(0, 1, 0, 5, 3, 0);
      add(0, 1, 0, 3, 4, 0);
      add(0, 1, 0, 2, 5, 0);
      add(0, 1, 0, 8, 0, 0);
    end
    // Reset in B green cycle 3 drops straight to all-red.
    add(0, 1, 0, 3, 1, 0);
    add(0, 1, 0, 2, 2, 0);
    add(0, 1, 0, 3, 3, 0);
    add(1, 0, 0, 1, 5, 0);
    add(0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 20, 0, 0);

    // A car after the minimum green yields at once; a request latched in B yellow
    // is wiped by reset, so A then rests.
    add(0, 1, 0, 3, 1, 0);
    add(0, 1, 0, 2, 2, 0);
    add(0, 1, 0, 5, 3, 0);
    add(0, 1, 0, 2, 4, 0);
    add(1, 0, 0, 1, 5, 0);
    add(0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 20, 0, 0);

`ifdef TLC_EMERGENCY_PREEMPT_EN
    // Emergency from B green cycle 2, held 10 cycles.
    add(1, 0, 0, 2, 5, 0);
    add(0, 0, 0, 1, 5, 0);
    add(0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 2, 3, 0);
    add(0, 0, 1, 3, 4, 0);
    add(0, 0, 1, 7, 5, 1);
    add(0, 0, 0, 2, 5, 0);
    add(0, 0, 0, 1, 0, 0);
    // Emergency in A green with a car: all-red AB returns to A, request kept.
    add(0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 2, 1, 0);
    add(0, 0, 1, 2, 2, 1);
    add(0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 2, 2, 0);
    add(0, 0, 0, 1, 3, 0);
`else
    // Without preemption the emergency input has no effect.
    add(0, 0, 1, 10, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i], i, k);
      end
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
